// File: rtl/regbank_pkg.sv
// regbank_pkg: shared enums and default constants for the multi-port register bank
package regbank_pkg;

    typedef enum logic [1:0] {
        SP_HOLD = 2'b00,
        SP_LOAD = 2'b01,
        SP_PUSH = 2'b10,
        SP_POP  = 2'b11
    } sp_op_e;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

    localparam int          DEF_DATA_W     = 32;
    localparam int          DEF_NUM_REGS   = 32;
    localparam logic [31:0] DEF_SP_RESET   = 32'h0000_03FF;
    localparam int          DEF_STACK_STEP = 4;

endpackage

// File: rtl/regbank_clear_seq.sv
// regbank_clear_seq: clear FSM sweeping indices 1..NUM_REGS-1, one per cycle
module regbank_clear_seq
    import regbank_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_idx,
    output logic          done
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // next state: start at index 1 on request, finish after the last index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done    = 1'b0;
        if (state_q == CLR_IDLE) begin
            if (clr_req) begin
                state_d = CLR_SWEEP;
                idx_d   = AW'(1);
            end
        end else begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NUM_REGS - 1)) begin
                state_d = CLR_IDLE;
                done    = 1'b1;
            end
        end
    end

    // state and sweep counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = (state_q == CLR_SWEEP);
    assign sweep_en  = busy;
    assign sweep_idx = idx_q;

endmodule

// File: rtl/regbank_mp.sv
// regbank_mp: N-read/1-write register bank with SP port, clear sweep and sticky wrap flag (bypass under REGBANK_BYPASS_EN)
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                NUM_REGS   = DEF_NUM_REGS,
    parameter int                NUM_RD     = 2,
    parameter int                SP_IDX     = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] SP_RESET   = DATA_W'(DEF_SP_RESET),
    parameter int                STACK_STEP = DEF_STACK_STEP,
    parameter int                AW         = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    input  logic                     rd_sp,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [1:0]               sp_op,
    input  logic [DATA_W-1:0]        sp_wdata,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     sp_wrap
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              sp_wrap_q, sp_wrap_d;
    logic              sweep_en, done;
    logic [AW-1:0]     sweep_idx;
    sp_op_e            op;
    logic [DATA_W-1:0] sp_cur, sp_new;
    logic [DATA_W:0]   sp_sum, sp_dif;
    logic              sp_carry, gpr_we, sp_we;

    regbank_clear_seq #(.NUM_REGS(NUM_REGS), .AW(AW)) u_clr (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .busy      (busy),
        .sweep_en  (sweep_en),
        .sweep_idx (sweep_idx),
        .done      (done)
    );

    assign wr_ready = !busy;
    assign op       = sp_op_e'(sp_op);
    assign sp_cur   = regs_q[SP_IDX];
    // the extra top bit of sum/difference is the carry/borrow that marks a wrap
    assign sp_sum   = {1'b0, sp_cur} + (DATA_W + 1)'(STACK_STEP);
    assign sp_dif   = {1'b0, sp_cur} - (DATA_W + 1)'(STACK_STEP);
    assign sp_new   = op == SP_LOAD ? sp_wdata :
                      op == SP_PUSH ? sp_dif[DATA_W-1:0] :
                      op == SP_POP  ? sp_sum[DATA_W-1:0] : sp_cur;
    assign sp_carry = (op == SP_PUSH && sp_dif[DATA_W]) || (op == SP_POP && sp_sum[DATA_W]);
    assign gpr_we   = wr_en && wr_ready && wr_addr != '0;
    assign sp_we    = wr_ready && op != SP_HOLD;

    // next array state: GPR write, then SP op (wins on SP_IDX), then sweep; r0 pinned to 0
    always_comb begin
        regs_d = regs_q;
        if (gpr_we) regs_d[wr_addr] = wr_data;
        if (sp_we) regs_d[SP_IDX] = sp_new;
        if (sweep_en) regs_d[sweep_idx] = (sweep_idx == AW'(SP_IDX)) ? SP_RESET : '0;
        regs_d[0] = '0;
        sp_wrap_d = done ? 1'b0 : (sp_wrap_q || (sp_we && sp_carry));
    end

    // register array and sticky wrap flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            sp_wrap_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            sp_wrap_q <= sp_wrap_d;
        end
    end

    assign sp_wrap = sp_wrap_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ea;
        assign ea = (k == 0 && rd_sp) ? AW'(SP_IDX) : rd_addr[k*AW +: AW];
`ifdef REGBANK_BYPASS_EN
        assign rd_data[k*DATA_W +: DATA_W] = ea == '0 ? '0 :
                                             (sp_we && ea == AW'(SP_IDX)) ? sp_new :
                                             (gpr_we && ea == wr_addr) ? wr_data : regs_q[ea];
`else
        assign rd_data[k*DATA_W +: DATA_W] = ea == '0 ? '0 : regs_q[ea];
`endif
    end

endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: directed self-checking bench for regbank_mp
module tb_regbank_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic        rd_sp;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [1:0]  sp_op;
    logic [31:0] sp_wdata;
    logic        clr_req;
    logic        busy;
    logic        sp_wrap;
    int          total = 0;
    int          bad = 0;
    int          cnt;

    regbank_mp dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_sp    (rd_sp),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .sp_op    (sp_op),
        .sp_wdata (sp_wdata),
        .clr_req  (clr_req),
        .busy     (busy),
        .sp_wrap  (sp_wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic fill();
        for (int i = 1; i < 31; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h0101_0101 * i + 32'h10;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        rd_sp = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk(tag, rd_data[31:0], (i == 31) ? 32'h3FF : 32'h0);
            chk(tag, rd_data[63:32], (i == 0) ? 32'h3FF : 32'h0);
        end
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_wrap"}, {31'h0, sp_wrap}, 32'h0);
        chk({tag, "_ready"}, {31'h0, wr_ready}, 32'h1);
    endtask

    initial begin
        reset = 1'b0; rd_addr = '0; rd_sp = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; sp_op = 2'b00; sp_wdata = '0; clr_req = 1'b0;
        tick();
        reset = 1'b1;
        check_cleared("reset");

        // GPR write, r0 protection
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        rd(5'd5, 5'd0);
`ifdef REGBANK_BYPASS_EN
        chk("r5_same_cycle", rd_data[31:0], 32'hDEAD_BEEF);
`else
        chk("r5_same_cycle", rd_data[31:0], 32'h0);
`endif
        tick();
        wr_en = 1'b0;
        rd(5'd5, 5'd0);
        chk("r5_read", rd_data[31:0], 32'hDEAD_BEEF);
        chk("r0_read", rd_data[63:32], 32'h0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        tick();
        wr_en = 1'b0;
        rd(5'd0, 5'd0);
        chk("r0_write_dropped", rd_data[31:0], 32'h0);
        chk("r0_write_dropped_p1", rd_data[63:32], 32'h0);

        // SP push/pop/load and wrap
        rd_sp = 1'b1; rd(5'd2, 5'd31);
        sp_op = 2'b10; tick();
        chk("sp_push", rd_data[31:0], 32'h3FB);
        chk("sp_push_p1", rd_data[63:32], 32'h3FB);
        sp_op = 2'b11; tick(); tick();
        chk("sp_pop2", rd_data[31:0], 32'h403);
        chk("sp_nowrap", {31'h0, sp_wrap}, 32'h0);
        sp_op = 2'b01; sp_wdata = 32'h2; tick();
        chk("sp_load", rd_data[31:0], 32'h2);
        sp_op = 2'b10; tick();
        chk("sp_push_wrap", rd_data[31:0], 32'hFFFF_FFFE);
        chk("sp_wrap_set", {31'h0, sp_wrap}, 32'h1);
        sp_op = 2'b11; tick();
        chk("sp_pop_back", rd_data[31:0], 32'h2);
        chk("sp_wrap_sticky", {31'h0, sp_wrap}, 32'h1);

        // SP op beats GPR write to SP_IDX
        sp_op = 2'b01; sp_wdata = 32'h100; tick();
        sp_op = 2'b10; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h55; tick();
        chk("sp_op_wins", rd_data[31:0], 32'hFC);
        sp_op = 2'b00; wr_data = 32'h77; tick();
        wr_en = 1'b0;
        chk("gpr_write_sp", rd_data[31:0], 32'h77);
        chk("wrap_kept", {31'h0, sp_wrap}, 32'h1);
        rd_sp = 1'b0;

        // same-cycle read of a GPR being written
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111; tick();
        wr_data = 32'hA5A5_A5A5; rd(5'd0, 5'd7);
`ifdef REGBANK_BYPASS_EN
        chk("r7_bypass", rd_data[63:32], 32'hA5A5_A5A5);
`else
        chk("r7_bypass", rd_data[63:32], 32'h1111_1111);
`endif
        tick();
        wr_en = 1'b0;
        chk("r7_after", rd_data[63:32], 32'hA5A5_A5A5);

        // full clear sweep with dropped write/SP op and ignored re-request
        fill();
        rd(5'd30, 5'd3);
        chk("fill_r30", rd_data[31:0], 32'h0101_0101 * 30 + 32'h10);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("sweep_busy", {31'h0, busy}, 32'h1);
        chk("sweep_not_ready", {31'h0, wr_ready}, 32'h0);
        cnt = 0;
        while (busy && cnt < 100) begin
            wr_en = (cnt == 5); wr_addr = 5'd3; wr_data = 32'hFFFF;
            sp_op = (cnt == 5) ? 2'b01 : 2'b00; sp_wdata = 32'h1;
            clr_req = (cnt == 7);
            tick();
            cnt++;
            if (cnt == 10) begin
                rd(5'd20, 5'd10);
                chk("mid_sweep_r20", rd_data[31:0], 32'h0101_0101 * 20 + 32'h10);
                chk("mid_sweep_r10", rd_data[63:32], 32'h0);
            end
        end
        wr_en = 1'b0; sp_op = 2'b00; clr_req = 1'b0;
        chk("busy_cycles", cnt, 32'd31);
        check_cleared("sweep");
        tick();
        chk("no_restart", {31'h0, busy}, 32'h0);

        // reset during sweep
        fill();
        sp_op = 2'b01; sp_wdata = 32'h0; tick();
        sp_op = 2'b10; tick(); sp_op = 2'b00;
        chk("wrap_again", {31'h0, sp_wrap}, 32'h1);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("busy_at_10", {31'h0, busy}, 32'h1);
        reset = 1'b0; tick(); reset = 1'b1;
        check_cleared("reset_mid_sweep");
        tick();
        chk("idle_after_reset", {31'h0, busy}, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFE; tick(); wr_en = 1'b0;
        rd(5'd20, 5'd21);
        chk("write_after_reset", rd_data[31:0], 32'hCAFE);
        chk("neighbour_after_reset", rd_data[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised successor to the processor's register bank.
- N read ports, one GPR write port, and a dedicated stack-pointer (SP) port that supports load, push and pop.
- Includes a multi-cycle clear sequencer and a sticky SP wrap flag.
- Sits between decode (read addresses) and writeback (write port, SP update) in the single-cycle/multi-cycle datapath.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (power of 2, ≥4); AW = $clog2(NUM_REGS)
- NUM_RD, 2, number of read ports
- SP_IDX, NUM_REGS-1, index of the stack-pointer register
- SP_RESET, 32'h000003FF, SP value after reset or clear
- STACK_STEP, 4, SP decrement on push / increment on pop

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset
- rd_addr  in  NUM_RD*AW  flattened read addresses; port k = bits [k*AW +: AW]
- rd_sp  in  1  when 1, read port 0 returns SP regardless of rd_addr[0]
- rd_data  out  NUM_RD*DATA_W  flattened read data, combinational
- wr_en  in  1  GPR write request
- wr_addr  in  AW  GPR write index
- wr_data  in  DATA_W  GPR write data
- wr_ready  out  1  write/SP port accepting (= !busy)
- sp_op  in  2  00 hold, 01 load, 10 push, 11 pop
- sp_wdata  in  DATA_W  SP load value
- clr_req  in  1  start clear sweep (pulse)
- busy  out  1  clear sweep in progress
- sp_wrap  out  1  sticky: an SP push/pop wrapped modulo 2^DATA_W

Behaviour:
- Reset (reset==0 at posedge):
  - All registers go to 0, except SP = SP_RESET.
  - busy=0, sp_wrap=0, FSM=IDLE.
  - Reset overrides everything, including a sweep in progress.
- r0 always reads 0. Writes to index 0 are dropped.
- Reads are combinational from array state.
  - A write accepted at edge N is visible to reads from edge N onward, i.e. 1-cycle write-to-read latency without bypass.
- GPR write: accepted at posedge when wr_en && wr_ready && wr_addr!=0.
- SP update: applied at posedge when wr_ready and sp_op!=00.
  - load: SP=sp_wdata.
  - push: SP=SP-STACK_STEP.
  - pop: SP=SP+STACK_STEP.
  - Arithmetic is DATA_W-bit unsigned, wrapping.
  - If a push/pop crosses 0 / 2^DATA_W, sp_wrap is set.
  - sp_wrap stays set until reset or clear-sweep completion.
- Simultaneous GPR write to SP_IDX and sp_op!=00: the sp_op result wins. With sp_op==00, the GPR write to SP_IDX is applied normally.
- Clear FSM states: IDLE, SWEEP.
  - IDLE→SWEEP on clr_req. The sweep index starts at 1.
  - In SWEEP, one register per cycle, in index order 1..NUM_REGS-1:
    - register[idx] is written 0, or SP_RESET when idx==SP_IDX;
    - idx increments.
  - After idx==NUM_REGS-1 is written: SWEEP→IDLE and sp_wrap cleared on that same edge.
  - busy is high for exactly NUM_REGS-1 cycles.
  - clr_req while busy is ignored.
  - While busy, wr_ready=0, and GPR writes and SP ops are dropped (not queued). Reads remain valid and return current array contents, partially cleared.
- Read port ordering: rd_sp affects port 0 only. Other ports read SP only when addressed at SP_IDX.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - Each read port whose effective address matches an accepted same-cycle write returns the write value combinationally.
  - For SP: the post-op SP value. For a GPR: wr_data. SP-op precedence applies.
  - Reads of r0 still return 0.
- Undefined: no bypass; same-cycle reads return the old value.

Decomposition:
- Package regbank_pkg:
  - sp_op enum (SP_HOLD, SP_LOAD, SP_PUSH, SP_POP);
  - clear FSM state enum (CLR_IDLE, CLR_SWEEP);
  - default constants DEF_DATA_W, DEF_NUM_REGS, DEF_SP_RESET, DEF_STACK_STEP.
- Sub-module regbank_clear_seq: clear FSM plus sweep counter. Outputs busy, sweep_en, sweep_idx, done pulse.

Test Plan:
- Reset low one edge, then high → every rd port reads 0 for all indices except SP_IDX = 0x3FF; busy=0, sp_wrap=0.
- Write r5=0xDEADBEEF, then read r5 and r0 on ports 0/1 next cycle → 0xDEADBEEF and 0. Write r0=0x1234 → r0 still reads 0.
- SP=0x3FF:
  - push → 0x3FB; pop ×2 → 0x403;
  - load 0x2, push → 0xFFFFFFFE with sp_wrap=1;
  - pop → 0x2, sp_wrap stays 1.
- Same cycle wr_addr=31, wr_data=0x55, sp_op=push with SP=0x100 → SP=0xFC.
- Fill r1..r30 with nonzero, pulse clr_req:
  - busy high exactly 31 cycles;
  - a write to r3 mid-sweep is dropped;
  - after busy falls: all regs 0, SP=0x3FF, sp_wrap=0.
  - Repeat with reset asserted at sweep cycle 10 → immediate full reset, busy=0.
- REGBANK_BYPASS_EN: write r7=0xA5A5A5A5 while port 1 reads r7 in the same cycle → 0xA5A5A5A5. Without the macro → old value.
